// File: rtl/spectrum_pkg.sv
// Shared types and constants for the spectrum upload path.
package spectrum_pkg;
    localparam int          BIN_W         = 64;
    localparam int          OUT_W         = 32;
    localparam logic [15:0] DEF_SYNC_WORD = 16'hA5A5;

    typedef enum logic [1:0] {
        IDLE,
        TRIG,
        COLLECT,
        DRAIN
    } state_e;
endpackage

// File: rtl/upload_skid_fifo.sv
// Single-clock 64-bit skid FIFO holding one upload burst; registered read port.
module upload_skid_fifo
    import spectrum_pkg::*;
#(
    parameter  int DEPTH = 512,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [BIN_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [BIN_W-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [BIN_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [BIN_W-1:0] rd_data_q, rd_data_d;
    logic             do_wr, do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        do_wr     = wr_en && !flush && (count_q != CW'(DEPTH));
        do_rd     = rd_en && !flush && (count_q != '0);
        wr_ptr_d  = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        rd_data_d = do_rd ? mem_q[rd_ptr_q] : rd_data_q;
        count_d   = count_q + CW'(do_wr) - CW'(do_rd);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Storage array is left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign empty   = (count_q == '0);
    assign count   = count_q;
endmodule

// File: rtl/spectrum_upload_ctrl.sv
// Upload controller: triggers the accumulation buffer, buffers one burst and re-emits it
// as a framed 32-bit valid/ready stream. Define SPECTRUM_UPLOAD_HEADER_EN to prepend a header word.
module spectrum_upload_ctrl
    import spectrum_pkg::*;
#(
    parameter int          BURST_LEN = 512,
    parameter int          TIMEOUT   = 1024,
    parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upload_en,
    input  logic [BIN_W-1:0] data_in,
    input  logic             valid_in,
    output logic             upload_trigger,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    input  logic             tx_ready,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_overrun
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef SPECTRUM_UPLOAD_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CW-1:0]    word_cnt_q, word_cnt_d, take_idx_q, take_idx_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [15:0]      burst_idx_q, burst_idx_d;
    logic             err_timeout_q, err_timeout_d, err_overrun_q, err_overrun_d;
    logic             rd_vld_q, rd_vld_d;
    logic             ser_vld_q, ser_vld_d, ser_half_q, ser_half_d;
    logic             ser_first_q, ser_first_d, ser_last_q, ser_last_d;
    logic [BIN_W-1:0] ser_word_q, ser_word_d;
    logic             hdr_pend_q, hdr_pend_d;
    logic             out_vld_q, out_vld_d, out_fs_q, out_fs_d, out_fe_q, out_fe_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;

    logic             fifo_rd, fifo_empty;
    logic [BIN_W-1:0] fifo_rdata;
    logic [CW-1:0]    fifo_count;
    logic             col_wr, timeout_hit, last_acc, pipe_idle;
    logic             ld_ok, emit_hdr, emit_ser, take;

    upload_skid_fifo #(.DEPTH(BURST_LEN)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (timeout_hit),
        .wr_en   (col_wr),
        .wr_data (data_in),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Handshake strobes. The FIFO read register acts as a one-word stage ahead of the
    // serializer so a fresh word is ready the cycle its predecessor's upper half leaves.
    always_comb begin
        col_wr      = valid_in && (state_q == COLLECT);
        timeout_hit = (state_q == COLLECT) && (word_cnt_q == '0) && !valid_in &&
                      (tmo_cnt_q == TW'(TIMEOUT - 1));
        last_acc    = out_vld_q && tx_ready && out_fe_q;
        pipe_idle   = (fifo_count == '0) && !rd_vld_q && !ser_vld_q && !hdr_pend_q && !out_vld_q;
        ld_ok       = !out_vld_q || tx_ready;
        emit_hdr    = ld_ok && hdr_pend_q;
        emit_ser    = ld_ok && !hdr_pend_q && ser_vld_q;
        take        = rd_vld_q && (!ser_vld_q || (emit_ser && ser_half_q));
        fifo_rd     = !fifo_empty && (!rd_vld_q || take);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (upload_en && pipe_idle) state_d = TRIG;
            TRIG:    state_d = COLLECT;
            COLLECT: begin
                if (timeout_hit) state_d = IDLE;
                else if (col_wr && (word_cnt_q == CW'(BURST_LEN - 1))) state_d = DRAIN;
            end
            DRAIN:   if (last_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        upload_trigger = (state_q == TRIG);
        busy           = (state_q != IDLE);
    end

    always_comb begin
        word_cnt_d    = word_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        burst_idx_d   = burst_idx_q;
        err_timeout_d = timeout_hit;
        err_overrun_d = valid_in && !col_wr;
        if (state_q == TRIG) begin
            word_cnt_d = '0;
            tmo_cnt_d  = '0;
        end
        if (col_wr) word_cnt_d = word_cnt_q + CW'(1);
        if (state_q == COLLECT) tmo_cnt_d = tmo_cnt_q + TW'(1);
        if ((state_q == DRAIN) && last_acc) burst_idx_d = burst_idx_q + 16'd1;
        else if ((state_q == IDLE) && !upload_en) burst_idx_d = '0;
    end

    always_comb begin
        rd_vld_d    = rd_vld_q;
        ser_vld_d   = ser_vld_q;
        ser_half_d  = ser_half_q;
        ser_first_d = ser_first_q;
        ser_last_d  = ser_last_q;
        ser_word_d  = ser_word_q;
        take_idx_d  = take_idx_q;
        hdr_pend_d  = hdr_pend_q;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_fs_d    = out_fs_q;
        out_fe_d    = out_fe_q;

        if (fifo_rd) rd_vld_d = 1'b1;
        else if (take) rd_vld_d = 1'b0;

        if (emit_ser) begin
            ser_half_d = !ser_half_q;
            if (ser_half_q) ser_vld_d = 1'b0;
        end
        if (take) begin
            ser_vld_d   = 1'b1;
            ser_half_d  = 1'b0;
            ser_word_d  = fifo_rdata;
            ser_first_d = (take_idx_q == '0);
            ser_last_d  = (take_idx_q == CW'(BURST_LEN - 1));
            take_idx_d  = take_idx_q + CW'(1);
        end

        if (emit_hdr) begin
            out_vld_d  = 1'b1;
            out_data_d = {SYNC_WORD, burst_idx_q};
            out_fs_d   = 1'b1;
            out_fe_d   = 1'b0;
            hdr_pend_d = 1'b0;
        end else if (emit_ser) begin
            out_vld_d  = 1'b1;
            out_data_d = ser_half_q ? ser_word_q[BIN_W-1:OUT_W] : ser_word_q[OUT_W-1:0];
            out_fs_d   = !HDR_EN && ser_first_q && !ser_half_q;
            out_fe_d   = ser_last_q && ser_half_q;
        end else if (ld_ok) begin
            out_vld_d  = 1'b0;
            out_fs_d   = 1'b0;
            out_fe_d   = 1'b0;
        end

        if (state_q == TRIG) begin
            hdr_pend_d = HDR_EN;
            take_idx_d = '0;
        end
        // An aborted burst never got data, so only the pending header needs discarding.
        if (timeout_hit) begin
            hdr_pend_d = 1'b0;
            rd_vld_d   = 1'b0;
            ser_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            take_idx_q    <= '0;
            tmo_cnt_q     <= '0;
            burst_idx_q   <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            rd_vld_q      <= 1'b0;
            ser_vld_q     <= 1'b0;
            ser_half_q    <= 1'b0;
            ser_first_q   <= 1'b0;
            ser_last_q    <= 1'b0;
            ser_word_q    <= '0;
            hdr_pend_q    <= 1'b0;
            out_vld_q     <= 1'b0;
            out_data_q    <= '0;
            out_fs_q      <= 1'b0;
            out_fe_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            take_idx_q    <= take_idx_d;
            tmo_cnt_q     <= tmo_cnt_d;
            burst_idx_q   <= burst_idx_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
            rd_vld_q      <= rd_vld_d;
            ser_vld_q     <= ser_vld_d;
            ser_half_q    <= ser_half_d;
            ser_first_q   <= ser_first_d;
            ser_last_q    <= ser_last_d;
            ser_word_q    <= ser_word_d;
            hdr_pend_q    <= hdr_pend_d;
            out_vld_q     <= out_vld_d;
            out_data_q    <= out_data_d;
            out_fs_q      <= out_fs_d;
            out_fe_q      <= out_fe_d;
        end
    end

    assign data_out    = out_data_q;
    assign valid_out   = out_vld_q;
    assign frame_start = out_fs_q;
    assign frame_end   = out_fe_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
endmodule
